// File: rtl/alu_cmd_issuer_pkg.sv
// Shared types for the ALU command issuer: widths, FSM states, command record.
// Optional feature macro used by this slice: ALU_CMD_FLAGS_EN.
package alu_pkg;

    localparam int ALU_DW    = 4;
    localparam int ALU_OPW   = 2;
    localparam int ALU_RW    = ALU_DW + 1;
    localparam int ALU_DEPTH = 4;

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        DONE
    } state_e;

    typedef struct packed {
        logic [ALU_DW-1:0]  a;
        logic [ALU_DW-1:0]  b;
        logic [ALU_OPW-1:0] opcode;
    } cmd_t;

endpackage

// File: rtl/alu_cmd_issuer_if.sv
// Bundle between command source, ALU and result consumer of the issuer.
// Groups: cmd_* (valid/ready in), a/b/opcode/op (ALU side), res_* (valid/ready
// out), busy. With ALU_CMD_FLAGS_EN defined, res_zero/res_carry are added.
interface alu_cmd_issuer_if;
    import alu_pkg::*;

    logic               cmd_valid;
    logic               cmd_ready;
    logic [ALU_DW-1:0]  cmd_a;
    logic [ALU_DW-1:0]  cmd_b;
    logic [ALU_OPW-1:0] cmd_opcode;

    logic [ALU_DW-1:0]  a;
    logic [ALU_DW-1:0]  b;
    logic [ALU_OPW-1:0] opcode;
    logic [ALU_RW-1:0]  op;

    logic               res_valid;
    logic               res_ready;
    logic [ALU_RW-1:0]  res_op;
    logic               busy;
`ifdef ALU_CMD_FLAGS_EN
    logic               res_zero;
    logic               res_carry;
`endif

    modport slave (
        input  cmd_valid, cmd_a, cmd_b, cmd_opcode,
        output cmd_ready,
        output a, b, opcode,
        input  op,
        output res_valid, res_op, busy,
`ifdef ALU_CMD_FLAGS_EN
        output res_zero, res_carry,
`endif
        input  res_ready
    );

    modport master (
        output cmd_valid, cmd_a, cmd_b, cmd_opcode,
        input  cmd_ready,
        input  a, b, opcode,
        output op,
        input  res_valid, res_op, busy,
`ifdef ALU_CMD_FLAGS_EN
        input  res_zero, res_carry,
`endif
        output res_ready
    );

endinterface

// File: rtl/alu_cmd_fifo.sv
// DEPTH-entry command FIFO (power-of-2 depth, pointers wrap naturally).
// Ports: clk, rst_n, push_i/data_i, pop_i/data_o (head), full_o, empty_o, count_o.
module alu_cmd_fifo
    import alu_pkg::*;
#(
    parameter int DEPTH = ALU_DEPTH
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push_i,
    input  cmd_t                   data_i,
    input  logic                   pop_i,
    output cmd_t                   data_o,
    output logic                   full_o,
    output logic                   empty_o,
    output logic [$clog2(DEPTH):0] count_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    cmd_t          mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [CW-1:0] count_q;
    logic          do_push;
    logic          do_pop;

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign data_o  = mem_q[rd_ptr_q];

    // Overflow/underflow attempts are ignored rather than corrupting state.
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            count_q <= count_q + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= data_i;
    end

endmodule

// File: rtl/alu_cmd_issuer.sv
// Issue stage feeding a combinational ALU: queues commands, issues one at a time,
// captures the result and offers it on a valid/ready port.
// Ports: clk, rst_n (async, active-low), bus (alu_cmd_issuer_if.slave).
// Macro ALU_CMD_FLAGS_EN adds registered res_zero/res_carry outputs.
module alu_cmd_issuer
    import alu_pkg::*;
#(
    parameter int DEPTH = ALU_DEPTH
) (
    input  logic              clk,
    input  logic              rst_n,
    alu_cmd_issuer_if.slave   bus
);

    state_e              state_q, state_d;
    cmd_t                cmd_q, cmd_d;
    logic [ALU_RW-1:0]   res_op_q, res_op_d;
    cmd_t                head;
    cmd_t                cmd_in;
    logic                empty;
    logic                full;
    logic [$clog2(DEPTH):0] count;
    logic                load;
    logic                push;

    assign cmd_in = '{a: bus.cmd_a, b: bus.cmd_b, opcode: bus.cmd_opcode};

    // Ready comes from the registered count only, so a same-cycle pop
    // never opens a slot for a push while full.
    assign bus.cmd_ready = (count != ($clog2(DEPTH)+1)'(DEPTH));
    assign push          = bus.cmd_valid && !full;

    alu_cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (push),
        .data_i  (cmd_in),
        .pop_i   (load),
        .data_o  (head),
        .full_o  (full),
        .empty_o (empty),
        .count_o (count)
    );

    always_comb begin
        state_d  = state_q;
        cmd_d    = cmd_q;
        res_op_d = res_op_q;
        load     = 1'b0;
        unique case (state_q)
            IDLE: load = !empty;
            EXEC: begin
                res_op_d = bus.op;
                state_d  = DONE;
            end
            DONE: begin
                if (bus.res_ready) begin
                    load    = !empty;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (load) begin
            cmd_d   = head;
            state_d = EXEC;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cmd_q    <= '0;
            res_op_q <= '0;
        end else begin
            state_q  <= state_d;
            cmd_q    <= cmd_d;
            res_op_q <= res_op_d;
        end
    end

    assign bus.a         = cmd_q.a;
    assign bus.b         = cmd_q.b;
    assign bus.opcode    = cmd_q.opcode;
    assign bus.res_op    = res_op_q;
    assign bus.res_valid = (state_q == DONE);
    assign bus.busy      = (state_q != IDLE) || !empty;

`ifdef ALU_CMD_FLAGS_EN
    logic zero_q, carry_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            zero_q  <= 1'b0;
            carry_q <= 1'b0;
        end else if (state_q == EXEC) begin
            zero_q  <= (bus.op[ALU_DW-1:0] == '0);
            carry_q <= bus.op[ALU_RW-1];
        end
    end

    assign bus.res_zero  = zero_q;
    assign bus.res_carry = carry_q;
`endif

endmodule

// File: tb/tb_alu_cmd_issuer.sv
// Bench for alu_cmd_issuer driving a 4-bit behavioural ALU.
// Vector table plus hand sequences; results checked through a scoreboard queue.
module tb_alu_cmd_issuer;
    import alu_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    alu_cmd_issuer_if bus ();

    alu_cmd_issuer #(.DEPTH(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // 00 add, 01 sub (borrow in MSB), 10 and, 11 or
    function automatic logic [4:0] alu_f(logic [3:0] a, logic [3:0] b,
                                         logic [1:0] opc);
        case (opc)
            2'b00:   return {1'b0, a} + {1'b0, b};
            2'b01:   return {1'b0, a} - {1'b0, b};
            2'b10:   return {1'b0, a & b};
            default: return {1'b0, a | b};
        endcase
    endfunction

    assign bus.op = alu_f(bus.a, bus.b, bus.opcode);

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic [1:0] opc;
        logic [4:0] exp;
    } vec_t;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    logic [4:0] exp_q[$];
    int res_cyc[$];
    logic [4:0] cur_exp;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard: push on command handshake, pop/compare on result handshake.
    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
        end else begin
            if (bus.cmd_valid && bus.cmd_ready)
                exp_q.push_back(cur_exp);
            if (bus.res_valid && bus.res_ready) begin
                res_cyc.push_back(cyc);
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_result: got %0h expected none",
                             bus.res_op);
                end else begin
                    logic [4:0] e;
                    e = exp_q.pop_front();
                    chk("res_op", bus.res_op, e);
`ifdef ALU_CMD_FLAGS_EN
                    chk("res_zero_flag", bus.res_zero, e[3:0] == 4'd0);
                    chk("res_carry_flag", bus.res_carry, e[4]);
`endif
                end
            end
        end
    end

    task automatic send(logic [3:0] a, logic [3:0] b, logic [1:0] opc,
                        logic [4:0] exp);
        bit ok;
        bus.cmd_a = a;
        bus.cmd_b = b;
        bus.cmd_opcode = opc;
        cur_exp = exp;
        bus.cmd_valid = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (bus.cmd_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            checks++;
            failures++;
            $display("FAIL cmd_accept_timeout: got no accept required accept");
        end
        @(posedge clk);
        #1;
        bus.cmd_valid = 1'b0;
    endtask

    task automatic wait_valid(string name);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (bus.res_valid) begin
                ok = 1'b1;
                break;
            end
        end
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL %s: got res_valid=0 required 1", name);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drain(string name);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && !bus.busy && !bus.res_valid) begin
                ok = 1'b1;
                break;
            end
        end
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL %s: got %0d pending required 0", name, exp_q.size());
        end
        @(posedge clk);
        #1;
    endtask

    vec_t vt[8];

    initial begin
        vt[0] = '{4'd4,  4'd13, 2'b00, 5'h11};
        vt[1] = '{4'd4,  4'd13, 2'b01, 5'h17};
        vt[2] = '{4'd4,  4'd13, 2'b10, 5'h04};
        vt[3] = '{4'd4,  4'd13, 2'b11, 5'h0D};
        vt[4] = '{4'd15, 4'd1,  2'b00, 5'h10};
        vt[5] = '{4'd3,  4'd5,  2'b01, 5'h1E};
        vt[6] = '{4'd10, 4'd12, 2'b10, 5'h08};
        vt[7] = '{4'd9,  4'd9,  2'b01, 5'h00};

        bus.cmd_valid = 1'b0;
        bus.cmd_a = '0;
        bus.cmd_b = '0;
        bus.cmd_opcode = '0;
        bus.res_ready = 1'b0;
        cur_exp = '0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_cmd_ready", bus.cmd_ready, 1);
        chk("rst_res_valid", bus.res_valid, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_a", bus.a, 0);
        chk("rst_res_op", bus.res_op, 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Single command latency
        bus.res_ready = 1'b1;
        send(4'b0100, 4'b1101, 2'b00, 5'h11);
        @(negedge clk);
        chk("lat_t0_valid", bus.res_valid, 0);
        chk("lat_t0_busy", bus.busy, 1);
        @(negedge clk);
        chk("lat_t1_valid", bus.res_valid, 0);
        chk("lat_t1_a", bus.a, 4'b0100);
        chk("lat_t1_b", bus.b, 4'b1101);
        @(negedge clk);
        chk("lat_t2_valid", bus.res_valid, 1);
        drain("drain_single");

        // Vector table
        for (int i = 0; i < 8; i++)
            send(vt[i].a, vt[i].b, vt[i].opc, vt[i].exp);
        drain("drain_table");

        // Burst: ordering and 2-cycle spacing
        res_cyc.delete();
        for (int i = 0; i < 4; i++)
            send(4'b0110, 4'b0011, 2'(i), alu_f(4'b0110, 4'b0011, 2'(i)));
        drain("drain_burst");
        chk("burst_count", res_cyc.size(), 4);
        if (res_cyc.size() == 4)
            for (int i = 1; i < 4; i++)
                chk("burst_spacing", res_cyc[i] - res_cyc[i-1], 2);

        // Fill to DEPTH behind a stalled result
        bus.res_ready = 1'b0;
        send(4'd1, 4'd2, 2'b00, 5'h03);
        wait_valid("fill_first_valid");
        for (int i = 2; i <= 5; i++)
            send(4'(i), 4'd1, 2'b01, 5'(i - 1));
        @(negedge clk);
        chk("fill_ready_low", bus.cmd_ready, 0);
        @(posedge clk);
        #1;
        bus.cmd_a = 4'd7;
        bus.cmd_b = 4'd7;
        bus.cmd_opcode = 2'b10;
        cur_exp = 5'h07;
        bus.cmd_valid = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("fill_held", bus.cmd_ready, 0);
        end
        @(posedge clk);
        #1;
        bus.res_ready = 1'b1;
        @(negedge clk);
        chk("fill_pop_cycle_ready", bus.cmd_ready, 0);
        @(negedge clk);
        chk("fill_after_pop_ready", bus.cmd_ready, 1);
        @(posedge clk);
        #1;
        bus.cmd_valid = 1'b0;
        drain("drain_fill");

        // Backpressure
        bus.res_ready = 1'b0;
        send(4'd8, 4'd3, 2'b00, 5'h0B);
        send(4'd12, 4'd2, 2'b01, 5'h0A);
        wait_valid("bp_valid");
        repeat (10) begin
            @(negedge clk);
            chk("bp_valid_hold", bus.res_valid, 1);
            chk("bp_res_hold", bus.res_op, 5'h0B);
            chk("bp_a_hold", bus.a, 4'd8);
        end
        @(posedge clk);
        #1;
        bus.res_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("bp_issue_a", bus.a, 4'd12);
        chk("bp_issue_valid", bus.res_valid, 0);
        drain("drain_bp");

`ifdef ALU_CMD_FLAGS_EN
        bus.res_ready = 1'b0;
        send(4'd0, 4'd0, 2'b00, 5'h00);
        wait_valid("flag_valid");
        chk("flag_zero", bus.res_zero, 1);
        chk("flag_carry", bus.res_carry, 0);
        bus.res_ready = 1'b1;
        drain("drain_flags");
`endif

        // Async reset mid-EXEC
        bus.res_ready = 1'b1;
        send(4'd9, 4'd6, 2'b00, 5'h0F);
        @(posedge clk);
        #2;
        chk("pre_rst_a", bus.a, 4'd9);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", bus.res_valid, 0);
        chk("mid_rst_a", bus.a, 0);
        chk("mid_rst_b", bus.b, 0);
        chk("mid_rst_ready", bus.cmd_ready, 1);
        chk("mid_rst_busy", bus.busy, 0);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        send(4'd2, 4'd3, 2'b11, 5'h03);
        drain("drain_post_rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
